// File: rtl/cmd_assembler.sv
// cmd_assembler: packs three received bytes (MSB first) into a 24-bit host
// command, holds it until acknowledged, and drops a partial frame when the
// gap between bytes of one command exceeds TIMEOUT clock cycles.
module cmd_assembler #(
   parameter int TIMEOUT = 20000,
   parameter int TO_W    = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_rdy,
   input  logic [7:0]  rx_data,
   input  logic        clr_cmd_rdy,
   output logic [23:0] cmd,
   output logic        cmd_rdy,
   output logic        overrun,
   output logic        frame_to
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_B1   = 2'd1,
      S_B2   = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   // Counter value at which an idle gap inside a frame is declared too long.
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
   localparam logic [TO_W-1:0] TO_ZERO = {TO_W{1'b0}};
   localparam logic [TO_W-1:0] TO_ONE  = {{(TO_W-1){1'b0}}, 1'b1};

   state_t          state_q;
   logic [23:0]     cmd_q;
   logic            cmd_rdy_q;
   logic            overrun_q;
   logic            frame_to_q;
   logic [TO_W-1:0] to_cnt_q;

   // Framing FSM with all outputs and the inter-byte timeout held in registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cmd_q      <= 24'h000000;
         cmd_rdy_q  <= 1'b0;
         overrun_q  <= 1'b0;
         frame_to_q <= 1'b0;
         to_cnt_q   <= TO_ZERO;
      end else begin
         // Pulses default low; they are raised for exactly one cycle below.
         overrun_q  <= 1'b0;
         frame_to_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               to_cnt_q <= TO_ZERO;
               if (rx_rdy) begin
                  cmd_q[23:16] <= rx_data;
                  state_q      <= S_B1;
               end else begin
                  state_q      <= S_IDLE;
               end
            end
            S_B1: begin
               // An arriving byte takes priority over an expiring timeout.
               if (rx_rdy) begin
                  cmd_q[15:8] <= rx_data;
                  to_cnt_q    <= TO_ZERO;
                  state_q     <= S_B2;
               end else if (to_cnt_q == TO_LAST) begin
                  to_cnt_q    <= TO_ZERO;
                  frame_to_q  <= 1'b1;
                  state_q     <= S_IDLE;
               end else begin
                  to_cnt_q    <= to_cnt_q + TO_ONE;
               end
            end
            S_B2: begin
               if (rx_rdy) begin
                  cmd_q[7:0]  <= rx_data;
                  cmd_rdy_q   <= 1'b1;
                  to_cnt_q    <= TO_ZERO;
                  state_q     <= S_HOLD;
               end else if (to_cnt_q == TO_LAST) begin
                  to_cnt_q    <= TO_ZERO;
                  frame_to_q  <= 1'b1;
                  state_q     <= S_IDLE;
               end else begin
                  to_cnt_q    <= to_cnt_q + TO_ONE;
               end
            end
            S_HOLD: begin
               to_cnt_q <= TO_ZERO;
               if (clr_cmd_rdy) begin
                  // Acknowledge frees the holding slot; a byte in the same
                  // cycle is already the first byte of the next command.
                  cmd_rdy_q <= 1'b0;
                  if (rx_rdy) begin
                     cmd_q[23:16] <= rx_data;
                     state_q      <= S_B1;
                  end else begin
                     state_q      <= S_IDLE;
                  end
               end else if (rx_rdy) begin
                  overrun_q <= 1'b1;
               end else begin
                  state_q   <= S_HOLD;
               end
            end
            default: begin
               state_q   <= S_IDLE;
               cmd_rdy_q <= 1'b0;
               to_cnt_q  <= TO_ZERO;
            end
         endcase
      end
   end

   assign cmd      = cmd_q;
   assign cmd_rdy  = cmd_rdy_q;
   assign overrun  = overrun_q;
   assign frame_to = frame_to_q;

endmodule
